// File: rtl/portal_msg_assembler.sv
// Turns a portal word stream (header word followed by payload words) into one
// wide message. Oversize messages are dropped whole and counted in err_count.
module portal_msg_assembler #(
    parameter int MAX_WORDS = 8
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   in_enq__ENA,
    input  logic [31:0]            in_enq_v,
    input  logic [15:0]            in_enq_length,
    output logic                   in_enq__RDY,
    output logic                   msg__ENA,
    output logic [7:0]             msg_method,
    output logic [3:0]             msg_count,
    output logic [32*MAX_WORDS-1:0] msg_data,
    input  logic                   msg__RDY,
    output logic [7:0]             err_count
);

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, EMIT} state_t;

    localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

    state_t      state;
    logic [3:0]  idx;
    logic [15:0] discard_cnt;
    logic        word_acc;
    logic        msg_xfer;
    logic [15:0] hdr_count;
    logic        unused_length;

    assign word_acc      = in_enq__ENA & in_enq__RDY;
    assign msg_xfer      = msg__ENA & msg__RDY;
    assign hdr_count     = in_enq_v[15:0];
    assign unused_length = ^in_enq_length;

    // RDY and ENA are registered and toggled together on entry to and exit
    // from EMIT, so neither depends on the current cycle's handshake inputs.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= IDLE;
            idx         <= 4'd0;
            discard_cnt <= 16'd0;
            msg_method  <= 8'd0;
            msg_count   <= 4'd0;
            msg_data    <= '0;
            msg__ENA    <= 1'b0;
            in_enq__RDY <= 1'b1;
            err_count   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (word_acc) begin
                        if (hdr_count == 16'd0) begin
                            msg_method  <= in_enq_v[31:24];
                            msg_count   <= 4'd0;
                            msg_data    <= '0;
                            msg__ENA    <= 1'b1;
                            in_enq__RDY <= 1'b0;
                            state       <= EMIT;
                        end else if (hdr_count <= MAX_COUNT) begin
                            msg_method <= in_enq_v[31:24];
                            msg_count  <= hdr_count[3:0];
                            msg_data   <= '0;
                            idx        <= 4'd0;
                            state      <= COLLECT;
                        end else begin
                            discard_cnt <= hdr_count;
                            state       <= DISCARD;
                        end
                    end
                end
                COLLECT: begin
                    if (word_acc) begin
                        for (int i = 0; i < MAX_WORDS; i++) begin
                            if (idx == 4'(i)) begin
                                msg_data[32*i +: 32] <= in_enq_v;
                            end
                        end
                        idx <= idx + 4'd1;
                        if (idx == msg_count - 4'd1) begin
                            msg__ENA    <= 1'b1;
                            in_enq__RDY <= 1'b0;
                            state       <= EMIT;
                        end
                    end
                end
                DISCARD: begin
                    if (word_acc) begin
                        discard_cnt <= discard_cnt - 16'd1;
                        if (discard_cnt == 16'd1) begin
                            state <= IDLE;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (msg_xfer) begin
                        msg__ENA    <= 1'b0;
                        in_enq__RDY <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_portal_msg_assembler.sv
// Directed and randomized checks of portal_msg_assembler against a stream-parsing
// reference model that works on whole messages rather than cycles.
module tb_portal_msg_assembler;

    localparam int MW = 8;
    localparam int DW = 32 * MW;

    typedef struct {
        logic [7:0]    method;
        logic [3:0]    count;
        logic [DW-1:0] data;
    } msg_t;

    logic          CLK;
    logic          nRST;
    logic          enq_ena;
    logic [31:0]   enq_v;
    logic [15:0]   enq_length;
    logic          enq_rdy;
    logic          msg_ena;
    logic [7:0]    msg_method;
    logic [3:0]    msg_count;
    logic [DW-1:0] msg_data;
    logic          msg_rdy;
    logic [7:0]    err_count;

    int checks;
    int errors;

    portal_msg_assembler #(.MAX_WORDS(MW)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .in_enq__ENA  (enq_ena),
        .in_enq_v     (enq_v),
        .in_enq_length(enq_length),
        .in_enq__RDY  (enq_rdy),
        .msg__ENA     (msg_ena),
        .msg_method   (msg_method),
        .msg_count    (msg_count),
        .msg_data     (msg_data),
        .msg__RDY     (msg_rdy),
        .err_count    (err_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic apply_stimulus(input logic ena, input logic [31:0] v);
        enq_ena    = ena;
        enq_v      = v;
        enq_length = 16'($urandom);
        tick();
    endtask

    task automatic check_msg(input string tag, input msg_t m);
        check_output({tag, "_ena"}, DW'(msg_ena), DW'(1));
        check_output({tag, "_method"}, DW'(msg_method), DW'(m.method));
        check_output({tag, "_count"}, DW'(msg_count), DW'(m.count));
        check_output({tag, "_data"}, msg_data, m.data);
    endtask

    // Reference: walk a complete word stream message by message.
    task automatic parse_stream(input logic [31:0] stream[$], inout msg_t q[$], inout int err);
        int i;
        i = 0;
        while (i < stream.size()) begin
            int c;
            logic [31:0] hdr;
            hdr = stream[i];
            i++;
            c = int'(hdr[15:0]);
            if (c <= MW) begin
                msg_t m;
                m.method = hdr[31:24];
                m.count  = 4'(c);
                m.data   = '0;
                for (int k = 0; k < c; k++) m.data[k*32 +: 32] = stream[i+k];
                q.push_back(m);
            end else begin
                err = (err + 1 > 255) ? 255 : err + 1;
            end
            i += c;
        end
    endtask

    initial begin
        msg_t        m;
        msg_t        exp_q[$];
        logic [31:0] stream[$];
        int          exp_err;
        int          pos;
        int          cyc;
        logic        accepted;

        checks     = 0;
        errors     = 0;
        nRST       = 1'b0;
        enq_ena    = 1'b0;
        enq_v      = 32'd0;
        enq_length = 16'd0;
        msg_rdy    = 1'b0;

        // Reset state
        tick();
        tick();
        nRST = 1'b1;
        check_output("rst_ena", DW'(msg_ena), DW'(0));
        check_output("rst_rdy", DW'(enq_rdy), DW'(1));
        check_output("rst_err", DW'(err_count), DW'(0));
        check_output("rst_data", msg_data, '0);
        check_output("rst_method", DW'(msg_method), DW'(0));
        check_output("rst_count", DW'(msg_count), DW'(0));

        // Two-word message, one-cycle latency, then back to IDLE
        msg_rdy = 1'b1;
        apply_stimulus(1'b1, 32'h0500_0002);
        apply_stimulus(1'b1, 32'hAAAA_0001);
        check_output("m2_no_early_ena", DW'(msg_ena), DW'(0));
        apply_stimulus(1'b1, 32'hBBBB_0002);
        enq_ena = 1'b0;
        m.method = 8'h05; m.count = 4'd2; m.data = '0;
        m.data[31:0] = 32'hAAAA_0001; m.data[63:32] = 32'hBBBB_0002;
        check_msg("m2", m);
        check_output("m2_rdy_low", DW'(enq_rdy), DW'(0));
        tick();
        check_output("m2_idle_ena", DW'(msg_ena), DW'(0));
        check_output("m2_idle_rdy", DW'(enq_rdy), DW'(1));

        // Zero-count header
        apply_stimulus(1'b1, 32'h0700_0000);
        enq_ena = 1'b0;
        m.method = 8'h07; m.count = 4'd0; m.data = '0;
        check_msg("m0", m);
        tick();
        check_output("m0_idle_ena", DW'(msg_ena), DW'(0));

        // Back-pressure: RDY low and outputs stable while the consumer stalls
        msg_rdy = 1'b0;
        apply_stimulus(1'b1, 32'h0900_0001);
        apply_stimulus(1'b1, 32'hCAFE_F00D);
        m.method = 8'h09; m.count = 4'd1; m.data = '0; m.data[31:0] = 32'hCAFE_F00D;
        for (int n = 0; n < 5; n++) begin
            check_msg("stall", m);
            check_output("stall_rdy", DW'(enq_rdy), DW'(0));
            apply_stimulus(1'b1, $urandom);
        end
        enq_ena = 1'b0;
        msg_rdy = 1'b1;
        check_msg("stall_release", m);
        tick();
        check_output("stall_idle_ena", DW'(msg_ena), DW'(0));
        check_output("stall_idle_rdy", DW'(enq_rdy), DW'(1));

        // Oversize message is swallowed and counted
        apply_stimulus(1'b1, 32'h0400_000A);
        for (int n = 0; n < 10; n++) begin
            check_output("disc_err_before", DW'(err_count), DW'(0));
            apply_stimulus(1'b1, $urandom);
            check_output("disc_no_ena", DW'(msg_ena), DW'(0));
        end
        check_output("disc_err_after", DW'(err_count), DW'(1));
        apply_stimulus(1'b1, 32'h0300_0001);
        apply_stimulus(1'b1, 32'h0000_BEEF);
        enq_ena = 1'b0;
        m.method = 8'h03; m.count = 4'd1; m.data = '0; m.data[31:0] = 32'h0000_BEEF;
        check_msg("after_disc", m);
        tick();

        // Reset mid-COLLECT abandons the partial message
        apply_stimulus(1'b1, 32'h0200_0003);
        apply_stimulus(1'b1, 32'h1111_1111);
        nRST = 1'b0;
        apply_stimulus(1'b0, 32'd0);
        nRST = 1'b1;
        check_output("rst_mid_ena", DW'(msg_ena), DW'(0));
        check_output("rst_mid_err", DW'(err_count), DW'(0));
        apply_stimulus(1'b1, 32'h0100_0001);
        check_output("rst_mid_no_ena", DW'(msg_ena), DW'(0));
        apply_stimulus(1'b1, 32'h1234_5678);
        enq_ena = 1'b0;
        m.method = 8'h01; m.count = 4'd1; m.data = '0; m.data[31:0] = 32'h1234_5678;
        check_msg("rst_mid_msg", m);
        check_output("rst_mid_err2", DW'(err_count), DW'(0));
        tick();

        // Randomized stream with random gaps and consumer stalls
        stream.delete();
        for (int n = 0; n < 14; n++) begin
            int c;
            c = $urandom_range(MW + 3, 0);
            stream.push_back({8'($urandom), 8'($urandom), 16'(c)});
            for (int k = 0; k < c; k++) stream.push_back($urandom);
        end
        exp_q.delete();
        exp_err = 0;
        parse_stream(stream, exp_q, exp_err);
        pos = 0;
        cyc = 0;
        while ((pos < stream.size() || exp_q.size() != 0) && cyc < 4000) begin
            enq_ena    = (pos < stream.size()) && ($urandom_range(3, 0) != 0);
            enq_v      = (pos < stream.size()) ? stream[pos] : $urandom;
            enq_length = 16'($urandom);
            msg_rdy    = ($urandom_range(2, 0) != 0);
            check_output("rand_rdy_vs_ena", DW'(enq_rdy), DW'(!msg_ena));
            if (msg_ena && msg_rdy) begin
                if (exp_q.size() == 0) begin
                    check_output("rand_unexpected_msg", DW'(msg_ena), DW'(0));
                end else begin
                    check_msg("rand_msg", exp_q.pop_front());
                end
            end
            accepted = enq_ena && enq_rdy;
            tick();
            if (accepted) pos++;
            cyc++;
        end
        enq_ena = 1'b0;
        check_output("rand_budget", DW'(cyc < 4000), DW'(1));
        tick();
        check_output("rand_final_ena", DW'(msg_ena), DW'(0));
        check_output("rand_err", DW'(err_count), DW'(exp_err));

        // Saturation of the discard counter
        nRST = 1'b0;
        apply_stimulus(1'b0, 32'd0);
        nRST = 1'b1;
        for (int n = 1; n <= 257; n++) begin
            apply_stimulus(1'b1, 32'h0600_0000 | 32'(MW + 1));
            for (int k = 0; k <= MW; k++) apply_stimulus(1'b1, $urandom);
            if (n >= 254) check_output("sat_err", DW'(err_count), DW'((n > 255) ? 255 : n));
        end
        enq_ena = 1'b0;
        check_output("sat_no_ena", DW'(msg_ena), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/portal_msg_assembler.md
PORTAL_MSG_ASSEMBLER -- requirements
Module: portal_msg_assembler

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 8, giving the maximum payload words per message (range 1..15).
REQ-002 SHALL have port CLK  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in$enq__ENA  input  1  word-stream enqueue strobe from the portal write path.
REQ-005 SHALL have port in$enq$v  input  32  stream word.
REQ-006 SHALL have port in$enq$length  input  16  portal length field; carried for interface compatibility and ignored.
REQ-007 SHALL have port in$enq__RDY  output  1  block can accept a word this cycle.
REQ-008 SHALL have port msg__ENA  output  1  assembled message valid.
REQ-009 SHALL have port msg$method  output  8  method id of the message.
REQ-010 SHALL have port msg$count  output  4  payload word count of the message.
REQ-011 SHALL have port msg$data  output  32*MAX_WORDS  payload; word i at bits [32i+31:32i].
REQ-012 SHALL have port msg__RDY  input  1  consumer accepts the message.
REQ-013 SHALL have port err_count  output  8  saturating count of discarded (oversize) messages.

Function
REQ-014 SHALL treat a word as transferred only in a cycle where in$enq__ENA & in$enq__RDY; ENA without RDY has no effect.
REQ-015 SHALL treat a message as transferred only in a cycle where msg__ENA & msg__RDY.
REQ-016 SHALL implement states IDLE, COLLECT, DISCARD, EMIT.
REQ-017 SHALL, in IDLE, interpret an accepted word as a header: method = v[31:24], count = v[15:0]; bits [23:16] ignored.
REQ-018 SHALL, for a header with count 0, latch the method, clear msg$data, and go to EMIT next cycle.
REQ-019 SHALL, for a header with 1 <= count <= MAX_WORDS, latch method and count, clear the word index and msg$data, and go to COLLECT.
REQ-020 SHALL, for a header with count > MAX_WORDS, load a 16-bit discard counter with count and go to DISCARD.
REQ-021 SHALL, in COLLECT, store each accepted word at the current index and then increment the index; after the word with index count-1, go to EMIT.
REQ-022 SHALL, in DISCARD, drop each accepted word and decrement the discard counter; on the final word, go to IDLE and increment err_count (saturating at 255); no msg__ENA.
REQ-023 SHALL, in EMIT, drive msg__ENA=1 with stable method/count/data until the message transfers; then go to IDLE in the next cycle.
REQ-024 SHALL drive in$enq__RDY = 1 in IDLE, COLLECT and DISCARD, and 0 in EMIT; no word is accepted in the transfer cycle.
REQ-025 SHALL keep latency from acceptance of the last payload word (or a count-0 header) to msg__ENA at exactly 1 cycle.
REQ-026 SHALL hold payload slots at index >= count at zero in msg$data.
REQ-027 SHALL drive msg$count from the low 4 bits of the accepted count; msg$count is never larger than MAX_WORDS.
REQ-028 SHALL use registered outputs only; msg__ENA, msg$* and in$enq__RDY SHALL NOT depend combinationally on in$enq__ENA or msg__RDY.

Reset
REQ-029 SHALL, when nRST=0 at posedge, enter IDLE; clear method, count, index, discard counter, msg$data and err_count to 0; set msg__ENA=0 and in$enq__RDY=1 from the next cycle.
REQ-030 SHALL abandon any partial or pending message on reset mid-COLLECT, mid-DISCARD or in EMIT; that message SHALL NOT be emitted.

Verification
REQ-031 Header 0x05000002, then words 0xAAAA0001 and 0xBBBB0002 on consecutive cycles, msg__RDY=1 -> one cycle later msg__ENA=1, method=0x05, count=2, data word0=0xAAAA0001, word1=0xBBBB0002, words 2..7 = 0; the next cycle returns to IDLE.
REQ-032 Header 0x07000000 -> msg__ENA=1 next cycle, method=0x07, count=0, data all zero.
REQ-033 Header count 10 with MAX_WORDS=8, then 10 words -> no msg__ENA at any point; err_count goes 0->1 after the 10th word; the following header is accepted.
REQ-034 Message pending with msg__RDY=0 for 5 cycles while in$enq__ENA=1 -> in$enq__RDY=0 and outputs stable for all 5 cycles; raise msg__RDY -> transfer, then IDLE in the next cycle.
REQ-035 Header count 3 plus one word, then nRST=0 for one cycle, then header 0x01000001 and word 0x12345678 -> single message method=0x01, count=1, word0=0x12345678; err_count=0.
REQ-036 Force 256 oversize messages -> err_count saturates at 0xFF.
